// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use and multicycle stalls, flushes, stall counter.
// Combinational outputs from current inputs and FSM state; multicycle op holds E for MC_LATENCY cycles.
module hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [4:0]        RdE,
    input  logic [4:0]        RdM,
    input  logic [4:0]        RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MultiE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              BusyE,
    output logic [PERF_W-1:0] StallCount
);

    localparam int CW = $clog2(MC_LATENCY);
    localparam logic [CW-1:0] MC_LOAD = CW'((MC_LATENCY > 2) ? (MC_LATENCY - 3) : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          postreset;
    logic          lw_stall, mc_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            postreset <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            postreset <= 1'b0;
        end
    end

    // DONE ignores MultiE so the op that just finished cannot retrigger itself.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (MultiE) begin
                    if (MC_LATENCY == 2) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = MC_LOAD;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mc_stall = ((state == IDLE) && MultiE) || (state == BUSY);

        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushM    = 1'b1;
        BusyE     = 1'b0;

        if (!reset) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

            StallF = lw_stall || mc_stall;
            StallD = lw_stall || mc_stall;
            StallE = mc_stall;
            FlushD = PCSrcE || postreset;
            FlushE = ((lw_stall || PCSrcE) && !mc_stall) || postreset;
            FlushM = mc_stall;
            BusyE  = (state == BUSY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != {PERF_W{1'b1}})) begin
            StallCount <= StallCount + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (MC_LATENCY 4 / PERF_W 32 and MC_LATENCY 2 / PERF_W 4)
// share stimulus; expected outputs are queued per step and popped when the outputs are sampled.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiE;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic        sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a;
    logic        sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_LATENCY(4), .PERF_W(32)) dut_a (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MultiE(MultiE),
        .ForwardAE(fa_a), .ForwardBE(fb_a),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
        .FlushD(fd_a), .FlushE(fe_a), .FlushM(fm_a),
        .BusyE(busy_a), .StallCount(cnt_a)
    );

    hazard_ctrl #(.MC_LATENCY(2), .PERF_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MultiE(MultiE),
        .ForwardAE(fa_b), .ForwardBE(fb_b),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
        .FlushD(fd_b), .FlushE(fe_b), .FlushM(fm_b),
        .BusyE(busy_b), .StallCount(cnt_b)
    );

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        sf, se, fd, fe, fm, busy;
        logic        sf2, fe2, busy2;
        logic [31:0] cnt;
        logic [3:0]  cnt2;
    } exp_t;

    exp_t        sbq[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] m_cnt  = 0;
    logic [3:0]  m_cnt2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, expv);
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; MultiE = 0;
    endtask

    task automatic expect_out(input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic se, input logic fd,
                              input logic fe, input logic fm, input logic busy,
                              input logic sf2, input logic fe2, input logic busy2);
        exp_t e;
        e.fa = fa; e.fb = fb; e.sf = sf; e.se = se; e.fd = fd; e.fe = fe;
        e.fm = fm; e.busy = busy; e.sf2 = sf2; e.fe2 = fe2; e.busy2 = busy2;
        e.cnt  = reset ? 32'd0 : m_cnt;
        e.cnt2 = reset ? 4'd0  : m_cnt2;
        sbq.push_back(e);
    endtask

    // Sample mid-cycle, then let the clock edge advance state and the reference counters.
    task automatic cycle();
        exp_t e;
        #2;
        if (sbq.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty at %0t: got no entry want one", $time);
            e = '0;
        end else begin
            e = sbq.pop_front();
            chk("ForwardAE", 32'(fa_a), 32'(e.fa));
            chk("ForwardBE", 32'(fb_a), 32'(e.fb));
            chk("StallF",    32'(sf_a), 32'(e.sf));
            chk("StallD",    32'(sd_a), 32'(e.sf));
            chk("StallE",    32'(se_a), 32'(e.se));
            chk("FlushD",    32'(fd_a), 32'(e.fd));
            chk("FlushE",    32'(fe_a), 32'(e.fe));
            chk("FlushM",    32'(fm_a), 32'(e.fm));
            chk("BusyE",     32'(busy_a), 32'(e.busy));
            chk("StallCount", cnt_a, e.cnt);
            chk("StallF_lat2",     32'(sf_b), 32'(e.sf2));
            chk("FlushE_lat2",     32'(fe_b), 32'(e.fe2));
            chk("BusyE_lat2",      32'(busy_b), 32'(e.busy2));
            chk("StallCount_sat4", 32'(cnt_b), 32'(e.cnt2));
        end
        @(posedge clk);
        if (reset) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (e.sf) m_cnt = m_cnt + 1;
            if (e.sf2 && m_cnt2 != 4'hF) m_cnt2 = m_cnt2 + 1;
        end
        @(negedge clk);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        @(negedge clk);

        // Reset held: outputs gated even with matching forward inputs and MultiE
        Rs1E = 5; RdM = 5; RegWriteM = 1; MultiE = 1;
        expect_out(0,0, 0,0,1,1,1,0, 0,1,0); cycle();

        reset = 1'b0; clr();
        expect_out(0,0, 0,0,1,1,0,0, 0,1,0); cycle();
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();

        // Forwarding priority and x0 exclusion
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        expect_out(2,0, 0,0,0,0,0,0, 0,0,0); cycle();
        RegWriteM = 0;
        expect_out(1,0, 0,0,0,0,0,0, 0,0,0); cycle();
        Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();
        clr(); Rs2E = 9; RdM = 9; RegWriteM = 1; Rs1E = 3; RdW = 3; RegWriteW = 1;
        expect_out(1,2, 0,0,0,0,0,0, 0,0,0); cycle();

        // Load-use
        clr(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        expect_out(0,0, 1,0,0,1,0,0, 1,1,0); cycle();
        RdE = 0; Rs2D = 0;
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();
        ResultSrcE0 = 0; RdE = 7; Rs1D = 7;
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();

        // Multicycle op held for four cycles
        clr(); MultiE = 1;
        expect_out(0,0, 1,1,0,0,1,0, 1,0,0); cycle();
        expect_out(0,0, 1,1,0,0,1,1, 0,0,0); cycle();
        expect_out(0,0, 1,1,0,0,1,1, 1,0,0); cycle();
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();
        MultiE = 0;
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();

        // Load-use overlapping a busy multicycle op
        MultiE = 1;
        expect_out(0,0, 1,1,0,0,1,0, 1,0,0); cycle();
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        expect_out(0,0, 1,1,0,0,1,1, 1,1,0); cycle();
        ResultSrcE0 = 0; RdE = 0; Rs1D = 0;
        expect_out(0,0, 1,1,0,0,1,1, 1,0,0); cycle();
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();
        MultiE = 0;
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();

        // Taken branch alone, then together with a multicycle op
        PCSrcE = 1;
        expect_out(0,0, 0,0,1,1,0,0, 0,1,0); cycle();
        MultiE = 1;
        expect_out(0,0, 1,1,1,0,1,0, 1,0,0); cycle();
        PCSrcE = 0;
        expect_out(0,0, 1,1,0,0,1,1, 0,0,0); cycle();
        expect_out(0,0, 1,1,0,0,1,1, 1,0,0); cycle();
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();
        MultiE = 0;
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();

        // Reset asserted mid-BUSY
        MultiE = 1;
        expect_out(0,0, 1,1,0,0,1,0, 1,0,0); cycle();
        expect_out(0,0, 1,1,0,0,1,1, 0,0,0); cycle();
        reset = 1'b1;
        expect_out(0,0, 0,0,1,1,1,0, 0,1,0); cycle();
        reset = 1'b0; MultiE = 0;
        expect_out(0,0, 0,0,1,1,0,0, 0,1,0); cycle();
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();

        // Counter saturation on the 4-bit instance
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        for (int i = 0; i < 20; i++) begin
            expect_out(0,0, 1,0,0,1,0,0, 1,1,0); cycle();
        end
        clr();
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();
        expect_out(0,0, 0,0,0,0,0,0, 0,0,0); cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
